// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first, one full-subtractor step per clock).
// Define SERIAL_SUBTRACTOR_ADD_EN to add an 'op' port selecting add (1) or subtract (0).
module serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_SUBTRACTOR_ADD_EN
   input  logic             op,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic             br;
   logic [CNT_W-1:0] cnt;
   logic             op_r;
   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] res_next;

   // Returns {borrow/carry out, result bit} for one bit position.
   function automatic logic [1:0] step_bit(input logic ai, input logic bi,
                                           input logic ci, input logic add);
      logic d;
      logic co;
      d = ai ^ bi ^ ci;
      if (add)
         co = (ai & bi) | (ci & (ai ^ bi));
      else
         co = (~ai & bi) | (~(ai ^ bi) & ci);
      return {co, d};
   endfunction

   always_comb begin
      {br_next, d_bit} = step_bit(a_sh[0], b_sh[0], br, op_r);
      res_next         = {d_bit, res_sh[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         op_r   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  res_sh <= '0;
                  br     <= 1'b0;
                  cnt    <= '0;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
                  op_r   <= op;
`else
                  op_r   <= 1'b0;
`endif
                  busy   <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_next;
               br     <= br_next;
               cnt    <= cnt + 1'b1;
               // Results are registered on the last step so they appear together with done.
               if (cnt == LAST_STEP) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  diff   <= res_next;
                  borrow <= br_next;
                  zero   <= (res_next == '0);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, corner sequences, random ops.
module tb_serial_subtractor;

   localparam int WIDTH = 16;
   localparam int LAT   = WIDTH + 1;

   logic             clk;
   logic             rst;
   logic             start;
   logic             op_s;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             zero;

   int total = 0;
   int bad   = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
`ifdef SERIAL_SUBTRACTOR_ADD_EN
      .op     (op_s),
`endif
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .zero   (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             op;
      logic [WIDTH-1:0] d;
      logic             br;
      logic             z;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Launch one operation and check latency, busy window, results and the return to idle.
   task automatic do_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                        input logic opi, input logic [WIDTH-1:0] exp_d,
                        input logic exp_br, input logic exp_z, input string nm);
      int lat;
      int busy_gap;
      logic [WIDTH-1:0] d_o;
      logic b_o;
      logic z_o;
      @(negedge clk);
      a = ai; b = bi; op_s = opi; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      op_s = 1'($urandom);
      lat = -1; busy_gap = 0;
      d_o = 'x; b_o = 1'bx; z_o = 1'bx;
      for (int n = 1; n <= 40; n++) begin
         if (!busy) busy_gap++;
         if (done) begin
            lat = n; d_o = diff; b_o = borrow; z_o = zero;
            break;
         end
         @(posedge clk); #1;
      end
      chk({nm, " latency"}, lat, LAT);
      chk({nm, " busy_gap"}, busy_gap, 0);
      chk({nm, " diff"}, d_o, exp_d);
      chk({nm, " borrow"}, b_o, exp_br);
      chk({nm, " zero"}, z_o, exp_z);
      @(posedge clk); #1;
      chk({nm, " done_after"}, done, 0);
      chk({nm, " busy_after"}, busy, 0);
      chk({nm, " diff_hold"}, diff, exp_d);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;
      int dcyc;
      logic [WIDTH-1:0] dval;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rop;
      logic [WIDTH-1:0] md;
      logic             mbr;
      logic [WIDTH:0]   sum;

      rst = 1'b1; start = 1'b0; a = '0; b = '0; op_s = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset diff", diff, 0);
      chk("reset borrow", borrow, 0);
      chk("reset zero", zero, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      vecs.push_back(vec_t'{a:16'h0005, b:16'h0003, op:1'b0, d:16'h0002, br:1'b0, z:1'b0});
      vecs.push_back(vec_t'{a:16'h0003, b:16'h0005, op:1'b0, d:16'hFFFE, br:1'b1, z:1'b0});
      vecs.push_back(vec_t'{a:16'h0000, b:16'hFFFF, op:1'b0, d:16'h0001, br:1'b1, z:1'b0});
      vecs.push_back(vec_t'{a:16'hFFFF, b:16'h0000, op:1'b0, d:16'hFFFF, br:1'b0, z:1'b0});
      vecs.push_back(vec_t'{a:16'h8000, b:16'h0001, op:1'b0, d:16'h7FFF, br:1'b0, z:1'b0});
      vecs.push_back(vec_t'{a:16'h1234, b:16'h1234, op:1'b0, d:16'h0000, br:1'b0, z:1'b1});
`ifdef SERIAL_SUBTRACTOR_ADD_EN
      vecs.push_back(vec_t'{a:16'hFFFF, b:16'h0001, op:1'b1, d:16'h0000, br:1'b1, z:1'b1});
      vecs.push_back(vec_t'{a:16'h0003, b:16'h0004, op:1'b1, d:16'h0007, br:1'b0, z:1'b0});
      vecs.push_back(vec_t'{a:16'h1234, b:16'h1234, op:1'b0, d:16'h0000, br:1'b0, z:1'b1});
`endif

      foreach (vecs[i])
         do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].d, vecs[i].br, vecs[i].z,
               $sformatf("vec%0d", i));

      // Last vector gave zero: results must hold while idle.
      repeat (5) @(posedge clk);
      #1;
      chk("idle hold diff", diff, 0);
      chk("idle hold zero", zero, 1);
      chk("idle hold borrow", borrow, 0);

      // start while busy must be ignored.
      @(negedge clk);
      a = 16'd9; b = 16'd4; op_s = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; dcyc = -1; dval = '0;
      for (int n = 1; n <= 30; n++) begin
         if (n == 5) begin a = 16'd1; b = 16'd1; start = 1'b1; end
         if (n == 6) start = 1'b0;
         if (done) begin
            ndone++;
            if (dcyc < 0) begin dcyc = n; dval = diff; end
         end
         @(posedge clk); #1;
      end
      chk("ignore ndone", ndone, 1);
      chk("ignore cycle", dcyc, LAT);
      chk("ignore diff", dval, 16'h0005);

      // Reset mid-operation aborts it.
      @(negedge clk);
      a = 16'h00FF; b = 16'h0001; op_s = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0;
      for (int n = 1; n < 8; n++) begin
         if (done) ndone++;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort done", done, 0);
      chk("abort diff", diff, 0);
      chk("abort borrow", borrow, 0);
      chk("abort zero", zero, 0);
      for (int n = 0; n < 25; n++) begin
         if (done) ndone++;
         @(posedge clk); #1;
      end
      chk("abort no_done", ndone, 0);
      do_op(16'h00FF, 16'h0001, 1'b0, 16'h00FE, 1'b0, 1'b0, "after_abort");

      // Random operations against an arithmetic reference.
      for (int i = 0; i < 24; i++) begin
         ra = WIDTH'($urandom);
         rb = (i % 6 == 0) ? ra : WIDTH'($urandom);
`ifdef SERIAL_SUBTRACTOR_ADD_EN
         rop = 1'($urandom);
`else
         rop = 1'b0;
`endif
         if (rop) begin
            sum = {1'b0, ra} + {1'b0, rb};
            md  = sum[WIDTH-1:0];
            mbr = sum[WIDTH];
         end else begin
            md  = WIDTH'((int'(ra) - int'(rb)) & ((1 << WIDTH) - 1));
            mbr = (ra < rb);
         end
         do_op(ra, rb, rop, md, mbr, (md == '0), $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
